mc_ctrl_fsm: RTL

Parametrised multi-cycle control unit for the shared instruction/data-memory MIPS datapath. It succeeds the fixed-latency controller with several additions:
- a memory ready handshake with timeout;
- a sticky error state;
- bne, jal and addi support;
- an internally resolved PC write enable;
- an instruction counter.

It sits between the IR opcode field and every datapath mux and register enable in the CPU top.

---
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_ctrl_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the MIPS datapath:
// IR opcode / memory handshake / ALU flag in, every mux select and enable out.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             alu_zero;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             reg_write;
    logic             alu_src_a;
    logic             pc_en;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic [3:0]       state;
    logic             err;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready, alu_zero,
        output mem_read, mem_write, iord, ir_write, reg_write, alu_src_a, pc_en,
               reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src, state, err, instr_count
    );

    modport slave (
        output opcode, mem_ready, alu_zero,
        input  mem_read, mem_write, iord, ir_write, reg_write, alu_src_a, pc_en,
               reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src, state, err, instr_count
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit with memory-ready timeout, sticky error and instruction count.
// Optional macro SINGLE_STEP_EN: park in HOLD after reset/each instruction until a step pulse.
//
// state   | meaning
// FETCH   | read instruction, PC <= PC+4 on mem_ready
// DECODE  | register read, branch target into ALUOut
// MEMADR  | compute lw/sw address
// MEMRD   | data read, wait for mem_ready
// MEMWB   | MDR -> rt
// MEMWR   | data write, wait for mem_ready
// EXEC    | R-type ALU operation
// RWB     | ALUOut -> rd
// BRANCH  | beq/bne compare and conditional PC load
// JUMP    | PC <= jump target
// JAL     | $31 <= PC, PC <= jump target
// ADDI_EX | rs + imm
// ADDI_WB | ALUOut -> rt
// HOLD    | single-step park (SINGLE_STEP_EN only)
// ERR     | sticky fault, left only by rst
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    mc_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RWB     = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_JAL     = 4'd10,
        ST_ADDI_EX = 4'd11,
        ST_ADDI_WB = 4'd12,
        ST_HOLD    = 4'd13,
        ST_ERR     = 4'd15
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

`ifdef SINGLE_STEP_EN
    localparam state_t DONE_ST = ST_HOLD;
`else
    localparam state_t DONE_ST = ST_FETCH;
`endif

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic              mem_state;
    logic              timeout;

    assign mem_state = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
    // A ready on the last allowed cycle still completes the access.
    assign timeout   = (MEM_TIMEOUT != 0) && !bus.mem_ready && (wait_q == WAIT_LAST);

    always_comb begin
        state_d        = state_q;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.pc_en      = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.mem_to_reg = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.pc_src     = 2'b00;
        case (state_q)
            ST_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                if (bus.mem_ready) state_d = ST_DECODE;
                else if (timeout)  state_d = ST_ERR;
            end
            ST_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    6'b100011, 6'b101011: state_d = ST_MEMADR;
                    6'b000000:            state_d = ST_EXEC;
                    6'b000100, 6'b000101: state_d = ST_BRANCH;
                    6'b000010:            state_d = ST_JUMP;
                    6'b000011:            state_d = ST_JAL;
                    6'b001000:            state_d = ST_ADDI_EX;
                    default:              state_d = ST_ERR;
                endcase
            end
            ST_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d = (bus.opcode == 6'b100011) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = ST_MEMWB;
                else if (timeout)  state_d = ST_ERR;
            end
            ST_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
                state_d = DONE_ST;
            end
            ST_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) state_d = DONE_ST;
                else if (timeout)  state_d = ST_ERR;
            end
            ST_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d = ST_RWB;
            end
            ST_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b01;
                state_d = DONE_ST;
            end
            ST_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                // opcode bit 0 separates bne from beq
                bus.pc_en     = bus.opcode[0] ? !bus.alu_zero : bus.alu_zero;
                state_d = DONE_ST;
            end
            ST_JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
                state_d = DONE_ST;
            end
            ST_JAL: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b10;
                bus.mem_to_reg = 2'b10;
                bus.pc_src     = 2'b10;
                bus.pc_en      = 1'b1;
                state_d = DONE_ST;
            end
            ST_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                bus.reg_write = 1'b1;
                state_d = DONE_ST;
            end
`ifdef SINGLE_STEP_EN
            ST_HOLD: begin
                if (step) state_d = ST_FETCH;
            end
`endif
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
        // Nothing reaches the datapath while reset is held, so an aborted write never lands.
        if (rst) begin
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.iord       = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.alu_src_a  = 1'b0;
            bus.pc_en      = 1'b0;
            bus.reg_dst    = 2'b00;
            bus.mem_to_reg = 2'b00;
            bus.alu_src_b  = 2'b00;
            bus.alu_op     = 2'b00;
            bus.pc_src     = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DONE_ST;
            wait_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_d == ST_ERR);
            if (state_d != state_q)
                wait_q <= '0;
            else if (mem_state && !bus.mem_ready)
                wait_q <= wait_q + 1'b1;
            if (bus.ir_write)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.state       = rst ? 4'd0 : state_q;
    assign bus.err         = !rst && err_q;
    assign bus.instr_count = rst ? '0 : cnt_q;
endmodule
